// File: rtl/ddr2_local_burst_master.sv
// ddr2_local_burst_master
//   Turns one (write/read, start word address, length) command into a sequence of
//   DDR2 controller local-interface bursts of at most MAX_BURST beats.
//   Optional build macro: DDR2_LBM_BOUNDARY_SPLIT_EN -- when defined, no burst crosses
//   a MAX_BURST-aligned address boundary; when undefined, bursts ignore alignment.
//   Handshake semantics: cmd_* and wr_* transfer on any cycle where valid & ready are
//   both high; the producer holds valid and payload stable until that cycle. The read
//   return stream (rd_valid/rd_data) is valid-only with no backpressure.
//   dbg_state exposes the FSM state encoding (IDLE=0, WR=1, RD_REQ=2, RD_WAIT=3, DONE=4).
module ddr2_local_burst_master #(
  parameter int ADDR_W    = 24,
  parameter int DATA_W    = 32,
  parameter int BE_W      = 4,
  parameter int SIZE_W    = 3,
  parameter int MAX_BURST = 4,
  parameter int LEN_W     = 16,
  parameter int MAX_OUTST = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic              done,
  input  logic              local_init_done,
  input  logic              local_ready,
  output logic [ADDR_W-1:0] local_address,
  output logic [SIZE_W-1:0] local_size,
  output logic              local_burstbegin,
  output logic              local_write_req,
  output logic              local_read_req,
  output logic [BE_W-1:0]   local_be,
  output logic [DATA_W-1:0] local_wdata,
  input  logic [DATA_W-1:0] local_rdata,
  input  logic              local_rdata_valid,
  output logic [2:0]        dbg_state
);

  // Wide enough for MAX_OUTST plus one in-flight burst.
  localparam int OUT_W = $clog2(MAX_OUTST + MAX_BURST + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR      = 3'd1,
    S_RD_REQ  = 3'd2,
    S_RD_WAIT = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic [LEN_W-1:0]  rem_q, rem_n;
  logic [SIZE_W-1:0] beat_q, beat_n;
  logic [OUT_W-1:0]  outst_q, outst_n;
  logic [LEN_W-1:0]  cap, bsz_len;
  logic [SIZE_W-1:0] bsz;
  logic              can_issue, issue, ret;

  assign local_be  = {BE_W{1'b1}};
  assign dbg_state = state;

  // Size of the burst starting at addr_q; addr_q/rem_q only move at burst ends,
  // so this stays constant for the whole burst.
  always_comb begin
`ifdef DDR2_LBM_BOUNDARY_SPLIT_EN
    cap = LEN_W'(MAX_BURST) - LEN_W'(addr_q % ADDR_W'(MAX_BURST));
`else
    cap = LEN_W'(MAX_BURST);
`endif
    bsz_len   = (rem_q < cap) ? rem_q : cap;
    bsz       = SIZE_W'(bsz_len);
    can_issue = (32'(outst_q) + 32'(bsz)) <= 32'(MAX_OUTST);
    // Returns with nothing outstanding (e.g. left over from before a reset) are dropped.
    ret       = local_rdata_valid && (outst_q != '0);
  end

  // Next-state, datapath updates and local/user interface outputs.
  always_comb begin
    state_n          = state;
    addr_n           = addr_q;
    rem_n            = rem_q;
    beat_n           = beat_q;
    issue            = 1'b0;
    cmd_ready        = 1'b0;
    wr_ready         = 1'b0;
    busy             = (state != S_IDLE);
    done             = 1'b0;
    local_address    = '0;
    local_size       = '0;
    local_burstbegin = 1'b0;
    local_write_req  = 1'b0;
    local_read_req   = 1'b0;
    local_wdata      = '0;
    case (state)
      S_IDLE: begin
        cmd_ready = local_init_done;
        if (cmd_valid && local_init_done) begin
          addr_n = cmd_addr;
          rem_n  = cmd_len;
          beat_n = '0;
          if (cmd_len == '0)  state_n = S_DONE;
          else if (cmd_write) state_n = S_WR;
          else                state_n = S_RD_REQ;
        end
      end
      S_WR: begin
        local_address    = addr_q;
        local_size       = bsz;
        local_write_req  = wr_valid;
        wr_ready         = local_ready;
        local_wdata      = wr_data;
        local_burstbegin = wr_valid && (beat_q == '0);
        if (wr_valid && local_ready) begin
          if (SIZE_W'(beat_q + SIZE_W'(1)) == bsz) begin
            beat_n = '0;
            addr_n = addr_q + ADDR_W'(bsz);
            rem_n  = rem_q - LEN_W'(bsz);
            if (rem_q == LEN_W'(bsz)) state_n = S_DONE;
          end else begin
            beat_n = beat_q + SIZE_W'(1);
          end
        end
      end
      S_RD_REQ: begin
        local_address    = addr_q;
        local_size       = bsz;
        // Outstanding count never grows while a request waits, so once raised
        // the request stays up until local_ready.
        local_read_req   = can_issue;
        local_burstbegin = can_issue;
        if (can_issue && local_ready) begin
          issue  = 1'b1;
          addr_n = addr_q + ADDR_W'(bsz);
          rem_n  = rem_q - LEN_W'(bsz);
          if (rem_q == LEN_W'(bsz)) state_n = S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        if ((outst_q == '0) && !rd_valid) state_n = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
    outst_n = outst_q + (issue ? OUT_W'(bsz) : OUT_W'(0)) - (ret ? OUT_W'(1) : OUT_W'(0));
  end

  // State, counters and the one-stage read return register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      addr_q   <= '0;
      rem_q    <= '0;
      beat_q   <= '0;
      outst_q  <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      state    <= state_n;
      addr_q   <= addr_n;
      rem_q    <= rem_n;
      beat_q   <= beat_n;
      outst_q  <= outst_n;
      rd_valid <= ret;
      if (ret) rd_data <= local_rdata;
    end
  end

endmodule

// File: tb/tb_ddr2_local_burst_master.sv
// Testbench for ddr2_local_burst_master: directed and randomized commands against a
// burst-splitting reference model and a simple local-interface controller model.
`timescale 1ns/1ps
module tb_ddr2_local_burst_master;
  localparam int ADDR_W = 24, DATA_W = 32, BE_W = 4, SIZE_W = 3;
  localparam int MAX_BURST = 4, LEN_W = 16, MAX_OUTST = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic              cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [ADDR_W-1:0] cmd_addr = '0;
  logic [LEN_W-1:0]  cmd_len = '0;
  logic [DATA_W-1:0] wr_data = '0, rd_data, local_wdata, local_rdata;
  logic              wr_valid = 1'b0, wr_ready, rd_valid, busy, done;
  logic              local_init_done = 1'b0, local_ready, local_rdata_valid;
  logic [ADDR_W-1:0] local_address;
  logic [SIZE_W-1:0] local_size;
  logic              local_burstbegin, local_write_req, local_read_req;
  logic [BE_W-1:0]   local_be;
  logic [2:0]        dbg_state;

  ddr2_local_burst_master dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .done(done),
    .local_init_done(local_init_done), .local_ready(local_ready),
    .local_address(local_address), .local_size(local_size),
    .local_burstbegin(local_burstbegin), .local_write_req(local_write_req),
    .local_read_req(local_read_req), .local_be(local_be), .local_wdata(local_wdata),
    .local_rdata(local_rdata), .local_rdata_valid(local_rdata_valid), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_cmp = 0, n_mis = 0;
  logic [DATA_W-1:0] exp_q[$];
  logic [ADDR_W-1:0] obs_w_addr[$], obs_r_addr[$];
  logic [SIZE_W-1:0] obs_w_size[$], obs_r_size[$];
  logic              obs_w_bb[$];
  logic [DATA_W-1:0] obs_w_data[$], obs_rd[$];
  logic [ADDR_W-1:0] mb_addr[$];
  int                mb_size[$];
  int pend_addr[$], pend_due[$];
  int done_cnt = 0, done_cyc = 0, last_rd_cyc = 0, outst_m = 0, outst_max = 0;
  logic rdy_random = 1'b0, rdy_force = 1'b1, hold_rd = 1'b0;
  int rd_lat = 2;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_mis++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Contents of controller memory at a word address.
  function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
    return {8'h00, a} * 32'h9E3779B1 + 32'h01234567;
  endfunction

  // Reference burst list: greedy split of [a, a+n) by the burst-size rule.
  function automatic void model_bursts(input logic [ADDR_W-1:0] a, input int n);
    int room, s;
    mb_addr.delete();
    mb_size.delete();
    while (n > 0) begin
      room = MAX_BURST;
`ifdef DDR2_LBM_BOUNDARY_SPLIT_EN
      room = MAX_BURST - (int'(a) % MAX_BURST);
`endif
      s = (n < room) ? n : room;
      mb_addr.push_back(a);
      mb_size.push_back(s);
      a = a + ADDR_W'(s);
      n -= s;
    end
  endfunction

  // ---------------- controller model ----------------
  initial begin
    local_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      local_ready = rdy_random ? ($urandom_range(0, 3) != 0) : rdy_force;
    end
  end

  initial begin
    local_rdata_valid = 1'b0;
    local_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (!hold_rd && pend_due.size() > 0 && pend_due[0] <= cyc) begin
        local_rdata_valid = 1'b1;
        local_rdata = mem_word(ADDR_W'(pend_addr[0]));
        void'(pend_addr.pop_front());
        void'(pend_due.pop_front());
      end else begin
        local_rdata_valid = 1'b0;
        local_rdata = $urandom;
      end
    end
  end

  // Monitor: record local-side transfers, returns and done pulses.
  always @(negedge clk) begin
    if (reset) begin
      outst_m = 0;
    end else begin
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (rd_valid) begin obs_rd.push_back(rd_data); last_rd_cyc = cyc; end
      if (local_write_req && local_ready) begin
        obs_w_addr.push_back(local_address);
        obs_w_size.push_back(local_size);
        obs_w_bb.push_back(local_burstbegin);
        obs_w_data.push_back(local_wdata);
      end
      if (local_read_req && local_ready) begin
        chk("outst_limit", 64'((outst_m + int'(local_size)) <= MAX_OUTST), 64'd1);
        obs_r_addr.push_back(local_address);
        obs_r_size.push_back(local_size);
        for (int i = 0; i < int'(local_size); i++) begin
          pend_addr.push_back(int'(local_address) + i);
          pend_due.push_back(cyc + rd_lat);
        end
        outst_m += int'(local_size);
      end
      if (local_rdata_valid && outst_m > 0) outst_m--;
      if (outst_m > outst_max) outst_max = outst_m;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic chk_idle(input string tag);
    chk({tag, " ctl"}, 64'({wr_ready, rd_valid, busy, done, local_burstbegin,
                            local_write_req, local_read_req}), 64'd0);
    chk({tag, " bus"}, 64'({local_address, local_size}), 64'd0);
    chk({tag, " data"}, 64'({local_wdata, rd_data}), 64'd0);
    chk({tag, " be"}, 64'(local_be), 64'hF);
  endtask

  task automatic run_cmd(input string tag, input logic wr, input logic [ADDR_W-1:0] a,
                         input int n, input int gap_pct, input bit stall,
                         input int hold_cycles, input int hold_exp, output int lat);
    int i, t, d0, acc, stall_left, stall_seen, k, off, sum;
    bit pending;
    obs_w_addr.delete(); obs_w_size.delete(); obs_w_bb.delete(); obs_w_data.delete();
    obs_r_addr.delete(); obs_r_size.delete(); obs_rd.delete(); exp_q.delete();
    model_bursts(a, n);
    d0 = done_cnt;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_len = LEN_W'(n);
    t = 0;
    do begin @(negedge clk); t++; end while (!cmd_ready && t < 50);
    chk({tag, " accept"}, 64'(cmd_ready), 64'd1);
    @(posedge clk); #1;
    acc = cyc;
    cmd_valid = 1'b0;
    i = 0; t = 0; pending = 1'b0; stall_left = 0; stall_seen = 0;
    while (wr && i < n && t < 2000) begin
      if (!pending) begin
        wr_valid = ($urandom_range(0, 99) >= gap_pct);
        if (wr_valid) wr_data = $urandom;
      end
      @(negedge clk); t++;
      if (stall_left > 0 && !local_ready) begin
        chk({tag, " stall_hold"},
            64'({local_write_req, wr_ready, local_burstbegin, local_address, local_size, local_wdata}),
            64'({1'b1, 1'b0, 1'b0, mb_addr[0], SIZE_W'(mb_size[0]), wr_data}));
        stall_seen++;
        stall_left--;
        if (stall_left == 0) rdy_force = 1'b1;
      end
      if (wr_valid && wr_ready) begin
        exp_q.push_back(wr_data);
        i++;
        pending = 1'b0;
        if (stall && i == 1) begin rdy_force = 1'b0; stall_left = 5; end
      end else begin
        pending = wr_valid;
      end
      @(posedge clk); #1;
    end
    wr_valid = 1'b0;
    if (stall) chk({tag, " stall_cycles"}, 64'(stall_seen), 64'd5);
    t = 0;
    if (hold_cycles > 0) hold_rd = 1'b1;
    while (done_cnt == d0 && t < 600) begin
      @(negedge clk); t++;
      if (hold_cycles > 0 && t == hold_cycles) begin
        sum = 0;
        foreach (obs_r_size[j]) sum += int'(obs_r_size[j]);
        chk({tag, " held_beats"}, 64'(sum), 64'(hold_exp));
        chk({tag, " held_req"}, 64'(local_read_req), 64'd0);
        hold_rd = 1'b0;
      end
    end
    hold_rd = 1'b0;
    lat = done_cyc - acc;
    repeat (3) @(negedge clk);
    chk({tag, " done_once"}, 64'(done_cnt - d0), 64'd1);
    if (wr) begin
      chk({tag, " wbeats"}, 64'(obs_w_addr.size()), 64'(n));
      chk({tag, " no_rd"}, 64'(obs_r_addr.size()), 64'd0);
      k = 0; off = 0;
      for (int j = 0; j < obs_w_addr.size() && j < n && j < exp_q.size(); j++) begin
        chk({tag, " wbeat"}, 64'({obs_w_addr[j], obs_w_size[j], obs_w_bb[j], obs_w_data[j]}),
            64'({mb_addr[k], SIZE_W'(mb_size[k]), off == 0, exp_q[j]}));
        off++;
        if (off == mb_size[k]) begin k++; off = 0; end
      end
    end else begin
      chk({tag, " bursts"}, 64'(obs_r_addr.size()), 64'(mb_addr.size()));
      chk({tag, " no_wr"}, 64'(obs_w_addr.size()), 64'd0);
      for (int j = 0; j < obs_r_addr.size() && j < mb_addr.size(); j++)
        chk({tag, " rburst"}, 64'({obs_r_addr[j], obs_r_size[j]}),
            64'({mb_addr[j], SIZE_W'(mb_size[j])}));
      chk({tag, " rbeats"}, 64'(obs_rd.size()), 64'(n));
      for (int j = 0; j < obs_rd.size() && j < n; j++)
        chk({tag, " rdata"}, 64'(obs_rd[j]), 64'(mem_word(a + ADDR_W'(j))));
      if (n > 0) chk({tag, " done_after_data"}, 64'(done_cyc > last_rd_cyc), 64'd1);
    end
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int lat, t, d0;
    logic wr;
    repeat (3) @(negedge clk);
    chk_idle("reset0");
    chk("reset0 cmd_ready", 64'(cmd_ready), 64'd0);
    local_init_done = 1'b1;
    @(negedge clk);
    chk("reset0 cmd_ready_init", 64'(cmd_ready), 64'd1);
    @(posedge clk); #1;
    reset = 1'b0;

    // Write, two aligned full bursts.
    run_cmd("t1", 1'b1, 24'h000010, 8, 0, 1'b0, 0, 0, lat);
    chk("t1 latency", 64'(lat), 64'd8);
    chk("t1 bursts", 64'({obs_w_addr[0], obs_w_addr[4], obs_w_bb[0], obs_w_bb[4], obs_w_bb[1]}),
        64'({24'h000010, 24'h000014, 1'b1, 1'b1, 1'b0}));

    // Read, one full burst and one short tail.
    rd_lat = 2;
    run_cmd("t2", 1'b0, 24'h000100, 6, 0, 1'b0, 0, 0, lat);
    chk("t2 bursts", 64'({obs_r_addr[0], obs_r_size[0], obs_r_addr[1], obs_r_size[1]}),
        64'({24'h000100, 3'd4, 24'h000104, 3'd2}));

    // Write with local_ready held low for five cycles on beat 1.
    run_cmd("t3", 1'b1, 24'h000020, 3, 0, 1'b1, 0, 0, lat);

    // Long read with returns withheld: outstanding limit must throttle requests.
    rd_lat = 1;
    outst_max = 0;
    run_cmd("t4", 1'b0, 24'h000200, 40, 0, 1'b0, 40, MAX_OUTST, lat);
    chk("t4 outst_max", 64'(outst_max), 64'(MAX_OUTST));

    // Unaligned start.
    run_cmd("t5", 1'b1, 24'h000006, 7, 0, 1'b0, 0, 0, lat);
`ifdef DDR2_LBM_BOUNDARY_SPLIT_EN
    chk("t5 split", 64'({obs_w_addr[0], obs_w_size[0], obs_w_addr[2], obs_w_size[2]}),
        64'({24'h000006, 3'd2, 24'h000008, 3'd4}));
    chk("t5 tail", 64'({obs_w_addr[6], obs_w_size[6]}), 64'({24'h00000C, 3'd1}));
`else
    chk("t5 nosplit", 64'({obs_w_addr[0], obs_w_size[0], obs_w_addr[4], obs_w_size[4]}),
        64'({24'h000006, 3'd4, 24'h00000A, 3'd3}));
`endif

    // Null command.
    run_cmd("t6", 1'b0, 24'h000300, 0, 0, 1'b0, 0, 0, lat);
    chk("t6 latency", 64'(lat <= 1), 64'd1);

    // Randomized commands, random ready, gaps, read latency, address wrap.
    rdy_random = 1'b1;
    for (int r = 0; r < 8; r++) begin
      wr = 1'($urandom_range(0, 1));
      rd_lat = $urandom_range(1, 4);
      run_cmd("rnd", wr, (r == 0) ? 24'hFFFFFD : ADDR_W'($urandom),
              $urandom_range(1, 20), 30, 1'b0, 0, 0, lat);
    end
    rdy_random = 1'b0;
    rdy_force = 1'b1;

    // Reset in the middle of a read.
    rd_lat = 2;
    d0 = done_cnt;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 24'h000400; cmd_len = 16'd40;
    t = 0;
    do begin @(negedge clk); t++; end while (!cmd_ready && t < 50);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (12) @(negedge clk);
    reset = 1'b1;
    #1;
    chk_idle("rst_mid");
    chk("rst_mid cmd_ready", 64'(cmd_ready), 64'(local_init_done));
    @(negedge clk);
    reset = 1'b0;
    obs_rd.delete();
    repeat (8) @(negedge clk);
    chk("rst_late_rdata", 64'(obs_rd.size()), 64'd0);
    chk("rst_no_done", 64'(done_cnt - d0), 64'd0);
    chk("rst_idle", 64'({busy, dbg_state}), 64'd0);
    local_init_done = 1'b0;
    @(negedge clk);
    chk("init_low cmd_ready", 64'(cmd_ready), 64'd0);
    local_init_done = 1'b1;
    @(negedge clk);
    chk("init_high cmd_ready", 64'(cmd_ready), 64'd1);
    repeat (40) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
